// File: rtl/bus_mem_responder.sv
// Purpose : burst-bus target backing onto a single-port SRAM; one burst at a time, round-robin AR/AW grant.
// Latency : first read beat 2 cycles after AR handshake; write beats land in SRAM on the accepting edge.
// Backpress: no rready (read beats contiguous); write bursts stall while wvalid is low. Optional BUS_MEM_RESPONDER_OOR_EN adds range check + oor_err.
module bus_mem_responder #(
    parameter int                ADDR_W    = 28,
    parameter int                DATA_W    = 32,
    parameter int                MEM_AW    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [3:0]          aruserid,
    input  logic                aruserap,
    input  logic [3:0]          arlen,
    output logic                rvalid,
    output logic [3:0]          rid,
    output logic                rlast,
    output logic [DATA_W-1:0]   rdata,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [3:0]          awuserid,
    input  logic                awuserap,
    input  logic [3:0]          awlen,
    input  logic                wvalid,
    output logic                wready,
    output logic [3:0]          wuserid,
    output logic                wlast,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                mem_en,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                mem_ap,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef BUS_MEM_RESPONDER_OOR_EN
    ,
    output logic                oor_err
`endif
);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_BEAT} state_t;

    state_t            state, state_nxt;
    logic              pri_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        id_q;
    logic [3:0]        len_q;
    logic              ap_q;
    logic [3:0]        beat_cnt;
    logic              beat_step;
    logic [ADDR_W-1:0] beat_addr;
    logic              beat_last;
    logic              beat_ok;
    logic              rd_vld_q;
    logic              rd_last_q;
    logic [3:0]        rd_id_q;

    // Per-beat address is computed at full bus width; the SRAM sees its low bits only.
    assign beat_addr = addr_q + ADDR_W'(beat_cnt);
    assign beat_last = (beat_cnt == len_q);

`ifdef BUS_MEM_RESPONDER_OOR_EN
    logic rd_oor_q;
    assign beat_ok = (beat_addr[ADDR_W-1:MEM_AW] == BASE_ADDR[ADDR_W-1:MEM_AW]);
    assign rdata   = rd_oor_q ? '0 : mem_rdata;
`else
    // Without the range check upper address bits simply alias.
    logic unused_bits;
    assign unused_bits = ^{beat_addr[ADDR_W-1:MEM_AW], BASE_ADDR};
    assign beat_ok     = 1'b1;
    assign rdata       = mem_rdata;
`endif

    assign rvalid = rd_vld_q;
    assign rid    = rd_id_q;
    assign rlast  = rd_last_q;

    // Next-state, request grant, write pacing and SRAM access generation.
    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        wuserid   = '0;
        wlast     = 1'b0;
        beat_step = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        mem_ap    = 1'b0;
        case (state)
            IDLE: begin
                arready = arvalid & (~awvalid | ~pri_wr);
                awready = awvalid & (~arvalid | pri_wr);
                if (arready)      state_nxt = RD_ISSUE;
                else if (awready) state_nxt = WR_BEAT;
            end
            RD_ISSUE: begin
                beat_step = 1'b1;
                if (beat_ok) begin
                    mem_en   = 1'b1;
                    mem_addr = beat_addr[MEM_AW-1:0];
                    mem_ap   = ap_q & beat_last;
                end
                if (beat_last) state_nxt = IDLE;
            end
            WR_BEAT: begin
                wready  = 1'b1;
                wuserid = id_q;
                wlast   = beat_last;
                if (wvalid) begin
                    beat_step = 1'b1;
                    if (beat_ok) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = beat_addr[MEM_AW-1:0];
                        mem_wdata = wdata;
                        mem_be    = wstrb;
                        mem_ap    = ap_q & beat_last;
                    end
                    if (beat_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and round-robin priority flip on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pri_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arready | awready) pri_wr <= ~pri_wr;
        end
    end

    // Latch the granted request and step the beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            ap_q     <= 1'b0;
            beat_cnt <= '0;
        end else if (arready) begin
            addr_q   <= araddr;
            id_q     <= aruserid;
            len_q    <= arlen;
            ap_q     <= aruserap;
            beat_cnt <= '0;
        end else if (awready) begin
            addr_q   <= awaddr;
            id_q     <= awuserid;
            len_q    <= awlen;
            ap_q     <= awuserap;
            beat_cnt <= '0;
        end else if (beat_step) begin
            beat_cnt <= beat_cnt + 4'd1;
        end
    end

    // Read-return info follows the SRAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_id_q   <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= (state == RD_ISSUE);
            rd_id_q   <= (state == RD_ISSUE) ? id_q : 4'd0;
            rd_last_q <= (state == RD_ISSUE) & beat_last;
        end
    end

`ifdef BUS_MEM_RESPONDER_OOR_EN
    // Out-of-range tracking: per-beat read-data squash and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_oor_q <= 1'b0;
            oor_err  <= 1'b0;
        end else begin
            rd_oor_q <= (state == RD_ISSUE) & ~beat_ok;
            if (beat_step & ~beat_ok) oor_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder with a behavioural 1-cycle SRAM.
// Inputs driven 1 time unit after posedge; outputs sampled 2 units after posedge.
// All expected values are hand-computed constants in the stimulus below.
module tb_bus_mem_responder;

    logic        clk;
    logic        rst;
    logic        arvalid, arready, aruserap;
    logic [27:0] araddr;
    logic [3:0]  aruserid, arlen;
    logic        rvalid, rlast;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        awvalid, awready, awuserap;
    logic [27:0] awaddr;
    logic [3:0]  awuserid, awlen;
    logic        wvalid, wready, wlast;
    logic [3:0]  wuserid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mem_en, mem_we, mem_ap;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
`ifdef BUS_MEM_RESPONDER_OOR_EN
    logic        oor_err;
`endif

    logic [31:0] sram [0:4095];
    int          n_checks;
    int          n_fail;
    int          wv [6];
    int          grants [4];
    int          n_g;
    int          both_hi;
    int          beat;
    logic [11:0] wrap_addr [4];
    logic [31:0] wrap_data [4];
    logic        wrap_en [4];

    bus_mem_responder dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .aruserid(aruserid),
        .aruserap(aruserap), .arlen(arlen),
        .rvalid(rvalid), .rid(rid), .rlast(rlast), .rdata(rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awuserid(awuserid),
        .awuserap(awuserap), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wuserid(wuserid), .wlast(wlast),
        .wdata(wdata), .wstrb(wstrb),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ap(mem_ap), .mem_rdata(mem_rdata)
`ifdef BUS_MEM_RESPONDER_OOR_EN
        , .oor_err(oor_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM, 1-cycle read latency, byte enables.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        arvalid = 0; araddr = 0; aruserid = 0; aruserap = 0; arlen = 0;
        awvalid = 0; awaddr = 0; awuserid = 0; awuserap = 0; awlen = 0;
        wvalid = 0; wdata = 0; wstrb = 0; mem_rdata = 0;
        for (int i = 0; i < 4096; i++) sram[i] = 32'h0;
        for (int i = 0; i < 4; i++) sram[12'h10 + i] = 32'(i + 1);
        sram[12'hFFE] = 32'h11; sram[12'hFFF] = 32'h22;
        sram[12'h000] = 32'h33; sram[12'h001] = 32'h44;
        sram[12'h052] = 32'hDEAD;
        wv = '{1, 0, 0, 1, 1, 1};

        // Reset state
        cyc(); cyc();
        #1;
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rlast", rlast, 0);
`ifdef BUS_MEM_RESPONDER_OOR_EN
        chk("rst_oor_err", oor_err, 0);
`endif
        rst = 1'b0;

        // Read burst addr 0x10 len 3 id 5
        cyc();
        arvalid = 1; araddr = 28'h10; arlen = 3; aruserid = 5; aruserap = 0;
        #1;
        chk("rd_arready", arready, 1);
        chk("rd_awready", awready, 0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            arvalid = 0;
            #1;
            chk($sformatf("rd_mem_en%0d", k), mem_en, (k <= 4));
            if (k <= 4) begin
                chk($sformatf("rd_mem_addr%0d", k), mem_addr, 12'h10 + 12'(k - 1));
                chk($sformatf("rd_mem_we%0d", k), mem_we, 0);
                chk($sformatf("rd_mem_ap%0d", k), mem_ap, 0);
            end
            chk($sformatf("rd_rvalid%0d", k), rvalid, (k >= 2 && k <= 5));
            chk($sformatf("rd_rlast%0d", k), rlast, (k == 5));
            if (k >= 2 && k <= 5) begin
                chk($sformatf("rd_rdata%0d", k), rdata, 32'(k - 1));
                chk($sformatf("rd_rid%0d", k), rid, 5);
            end
        end

        // Write burst addr 0x20 len 3 id 9 with a 2-cycle stall before beat 2
        cyc();
        awvalid = 1; awaddr = 28'h20; awlen = 3; awuserid = 9; awuserap = 0;
        #1;
        chk("wr_awready", awready, 1);
        beat = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            awvalid = 0;
            wvalid = (wv[i] != 0);
            wdata = 32'hA0 + 32'(beat);
            wstrb = 4'hF;
            #1;
            chk($sformatf("wr_wready%0d", i), wready, 1);
            chk($sformatf("wr_wuserid%0d", i), wuserid, 9);
            chk($sformatf("wr_wlast%0d", i), wlast, (beat == 3));
            chk($sformatf("wr_mem_en%0d", i), mem_en, wv[i]);
            if (wv[i] != 0) begin
                chk($sformatf("wr_mem_addr%0d", i), mem_addr, 12'h20 + 12'(beat));
                chk($sformatf("wr_mem_wdata%0d", i), mem_wdata, 32'hA0 + 32'(beat));
                chk($sformatf("wr_mem_be%0d", i), mem_be, 4'hF);
            end
            beat += wv[i];
        end
        cyc();
        wvalid = 0;
        #1;
        chk("wr_wready_drop", wready, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wr_sram%0d", i), sram[12'h20 + i], 32'hA0 + 32'(i));

        // Byte-strobe write
        cyc();
        awvalid = 1; awaddr = 28'h30; awlen = 0; awuserid = 1;
        cyc();
        awvalid = 0; wvalid = 1; wdata = 32'hFFFF_FFFF; wstrb = 4'b0101;
        #1;
        chk("strb_wlast", wlast, 1);
        chk("strb_mem_be", mem_be, 4'b0101);
        cyc();
        wvalid = 0;
        #1;
        chk("strb_sram", sram[12'h30], 32'h00FF_00FF);
        chk("strb_wready", wready, 0);

        // Round robin with both valids held from reset
        cyc(); rst = 1;
        cyc(); rst = 0;
        arvalid = 1; araddr = 28'h40; arlen = 0; aruserid = 1;
        awvalid = 1; awaddr = 28'h41; awlen = 0; awuserid = 2;
        wvalid = 1; wdata = 32'h77; wstrb = 4'hF;
        n_g = 0; both_hi = 0;
        for (int i = 0; i < 4; i++) grants[i] = 2;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (arready && awready) both_hi++;
            if (arready && n_g < 4) begin grants[n_g] = 0; n_g++; end
            else if (awready && n_g < 4) begin grants[n_g] = 1; n_g++; end
            cyc();
        end
        arvalid = 0; awvalid = 0; wvalid = 0;
        chk("rr_both", both_hi, 0);
        chk("rr_g0_rd", grants[0], 0);
        chk("rr_g1_wr", grants[1], 1);
        chk("rr_g2_rd", grants[2], 0);
        chk("rr_sram", sram[12'h41], 32'h77);

        // Wrap at SRAM top: addr 0xFFE len 3
        wrap_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
`ifdef BUS_MEM_RESPONDER_OOR_EN
        wrap_en   = '{1'b1, 1'b1, 1'b0, 1'b0};
        wrap_data = '{32'h11, 32'h22, 32'h0, 32'h0};
`else
        wrap_en   = '{1'b1, 1'b1, 1'b1, 1'b1};
        wrap_data = '{32'h11, 32'h22, 32'h33, 32'h44};
`endif
        cyc();
        arvalid = 1; araddr = 28'hFFE; arlen = 3; aruserid = 7;
        #1;
        chk("wrap_arready", arready, 1);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            arvalid = 0;
            #1;
            if (k <= 4) begin
                chk($sformatf("wrap_mem_en%0d", k), mem_en, wrap_en[k-1]);
                if (wrap_en[k-1]) chk($sformatf("wrap_mem_addr%0d", k), mem_addr, wrap_addr[k-1]);
            end
            if (k >= 2) begin
                chk($sformatf("wrap_rvalid%0d", k), rvalid, 1);
                chk($sformatf("wrap_rdata%0d", k), rdata, wrap_data[k-2]);
                chk($sformatf("wrap_rlast%0d", k), rlast, (k == 5));
            end
        end
`ifdef BUS_MEM_RESPONDER_OOR_EN
        chk("wrap_oor_err", oor_err, 1);
`endif

        // Reset during beat 2 of a len 7 write burst
        cyc();
        awvalid = 1; awaddr = 28'h50; awlen = 7; awuserid = 3;
        cyc();
        awvalid = 0; wvalid = 1; wdata = 32'h500; wstrb = 4'hF;
        #1;
        chk("rstw_beat1_we", mem_we, 1);
        cyc();
        wdata = 32'h501; rst = 1;
        cyc();
        rst = 0; wdata = 32'h502;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk($sformatf("rstw_mem_en%0d", j), mem_en, 0);
            chk($sformatf("rstw_mem_we%0d", j), mem_we, 0);
            chk($sformatf("rstw_wready%0d", j), wready, 0);
            chk($sformatf("rstw_rvalid%0d", j), rvalid, 0);
            chk($sformatf("rstw_awready%0d", j), awready, 0);
            cyc();
        end
        wvalid = 0;
        chk("rstw_sram52", sram[12'h52], 32'hDEAD);
`ifdef BUS_MEM_RESPONDER_OOR_EN
        chk("rstw_oor_err", oor_err, 0);
`endif

        // Single-beat read with auto-precharge
        arvalid = 1; araddr = 28'h60; arlen = 0; aruserid = 2; aruserap = 1;
        #1;
        chk("ap_arready", arready, 1);
        cyc();
        arvalid = 0; aruserap = 0;
        #1;
        chk("ap_mem_en", mem_en, 1);
        chk("ap_mem_ap", mem_ap, 1);
        chk("ap_mem_addr", mem_addr, 12'h60);
        cyc();
        #1;
        chk("ap_mem_ap_off", mem_ap, 0);
        chk("ap_mem_en_off", mem_en, 0);
        chk("ap_rvalid", rvalid, 1);
        chk("ap_rlast", rlast, 1);
        chk("ap_rid", rid, 2);
        cyc();
        #1;
        chk("ap_rvalid_off", rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Bus-side target (responder) for the 28-bit address / 32-bit data burst bus that the UART bridge and other initiators drive.
- Accepts read-address (ar*) and write-address (aw*) requests, sequences incrementing bursts of arlen/awlen+1 beats, and returns read beats (rid/rlast/rvalid).
- Paces write beats with wready/wuserid/wlast.
- Backs onto a single-port synchronous SRAM with 1-cycle read latency.
- One burst in flight at a time.

Parameters:
ADDR_W, 28, bus word-address width
DATA_W, 32, data width (strobe width = DATA_W/8)
MEM_AW, 12, SRAM word-address width (depth 2^MEM_AW)
BASE_ADDR, 28'h000_0000, bus address of SRAM word 0 (aligned to 2^MEM_AW)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arvalid  in  1  read request valid
arready  out  1  read request accepted
araddr  in  ADDR_W  burst start word address
aruserid  in  4  read transaction id
aruserap  in  1  auto-precharge/close flag for read burst
arlen  in  4  read beats minus one
rvalid  out  1  read beat valid
rid  out  4  id of current read beat
rlast  out  1  final read beat
rdata  out  DATA_W  read data
awvalid  in  1  write request valid
awready  out  1  write request accepted
awaddr  in  ADDR_W  burst start word address
awuserid  in  4  write transaction id
awuserap  in  1  auto-precharge/close flag for write burst
awlen  in  4  write beats minus one
wvalid  in  1  write beat valid
wready  out  1  responder ready for write beat
wuserid  out  4  id of write burst being accepted
wlast  out  1  current accepted beat is final
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  MEM_AW  SRAM word address
mem_wdata  out  DATA_W  SRAM write data
mem_be  out  DATA_W/8  SRAM byte enables
mem_ap  out  1  close pulse on final access of a userap burst
mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en&!mem_we

Behaviour:
- Reset: state IDLE, pri_wr=0. All outputs 0 on the next edge. Reset mid-burst aborts the burst, with no further mem_en.
- FSM states: IDLE, RD_ISSUE, WR_BEAT.
- IDLE, ready generation (combinational from valids):
  - arready = arvalid & (!awvalid | !pri_wr)
  - awready = awvalid & (!arvalid | pri_wr)
  - Never both high.
- IDLE, on handshake: latch addr, id, len, ap; clear beat_cnt. Read goes to RD_ISSUE, write goes to WR_BEAT.
- pri_wr toggles after each granted request (round robin). It has no effect when only one valid is high.
- RD_ISSUE, per cycle:
  - mem_en=1, mem_we=0, mem_addr = start[MEM_AW-1:0] + beat_cnt, mod 2^MEM_AW (wraps at SRAM top).
  - One issue per cycle. After beat len, go to IDLE.
- Read return:
  - rvalid, rid and rlast are registered copies of issue-cycle info, delayed 1 cycle.
  - rdata = mem_rdata, passed through directly.
  - First rvalid 2 cycles after the AR handshake. Beats are contiguous; there is no rready.
  - rlast accompanies beat len.
  - The next request can be accepted in the cycle rlast is high.
- WR_BEAT:
  - wready=1, wuserid=latched id, wlast=(beat_cnt==len).
  - On wvalid: mem_en=1, mem_we=1, mem_be=wstrb, mem_wdata=wdata, mem_addr as in reads; beat_cnt++.
  - wvalid low means no access; the burst stalls indefinitely.
  - Final beat goes to IDLE; wready drops the next cycle.
- mem_ap = latched ap & final SRAM access of the burst (read issue or write beat).
- Address above MEM_AW is ignored (aliases).
- len=0 is a single beat, with rlast/wlast on that beat.
- Outside RD_ISSUE/WR_BEAT-with-wvalid, mem_en=0 and the other mem_* outputs are 0.

Optional Feature:
- BUS_MEM_RESPONDER_OOR_EN defined:
  - A beat is out of range when its address bits [ADDR_W-1:MEM_AW] != BASE_ADDR[ADDR_W-1:MEM_AW], with the per-beat address computed at ADDR_W width.
  - Out-of-range beats do not assert mem_en. Read data on those beats is forced to 0.
  - Adds output oor_err (1 bit), which is sticky, set on the first out-of-range beat and cleared only by rst. Handshakes are unchanged.
- Undefined: oor_err is absent and all addresses alias modulo 2^MEM_AW.

Test Plan:
- Preload SRAM[0x10..0x13]=1..4; AR addr=0x10, len=3, id=5 -> rvalid for cycles T+2..T+5, rdata 1,2,3,4, rid=5, rlast only on 4th.
- AW addr=0x20, len=3, id=9; wvalid low on beat 2 for 2 cycles -> wuserid=9, wlast on beat 4 only, SRAM[0x20..0x23]=wdata, stall causes no mem_en.
- Write wstrb=4'b0101 over 0xFFFFFFFF at SRAM[0x30]=0 -> SRAM[0x30]=0x00FF00FF.
- arvalid and awvalid held together from reset -> read granted first, then write, then read (round robin); arready and awready never simultaneous.
- AR addr=0xFFE, len=3 -> mem_addr 0xFFE,0xFFF,0x000,0x001; with BUS_MEM_RESPONDER_OOR_EN, last two beats rdata=0, no mem_en, oor_err=1.
- rst pulsed during beat 2 of len=7 write burst, with aruserap=1 on a later read -> no further mem_we after rst, all outputs 0; subsequent read len=0 gives mem_ap pulse on its single issue cycle.
